// File: rtl/spi_ram_burst_if.sv
// Bus between the SPI slave and the burst RAM: command words in,
// read data out through a valid/ready handshake, plus sticky error flags.
interface spi_ram_burst_if #(
    parameter int MEM_WIDTH = 8
);
    logic                 rx_valid;
    logic [MEM_WIDTH+1:0] din;
    logic                 tx_ready;
    logic                 clr_err;
    logic [MEM_WIDTH-1:0] dout;
    logic                 tx_valid;
    logic                 overrun;
    logic                 addr_err;

    // SPI slave side: issues commands, consumes read data.
    modport master (
        output rx_valid, din, tx_ready, clr_err,
        input  dout, tx_valid, overrun, addr_err
    );

    // RAM side: decodes commands, produces read data.
    modport slave (
        input  rx_valid, din, tx_ready, clr_err,
        output dout, tx_valid, overrun, addr_err
    );
endinterface

// File: rtl/spi_ram_burst.sv
// Command-decoded single-port RAM behind an SPI slave. Separate write and
// read pointers (optionally auto-incrementing with wrap at MEM_DEPTH-1),
// a two-state transmit holder with back-pressure, and sticky overrun /
// address-error flags. MEM_DEPTH need not be a power of two.
module spi_ram_burst #(
    parameter int MEM_WIDTH = 8,
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256,
    parameter bit AUTO_INC  = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    spi_ram_burst_if.slave bus
);

    // Index width actually needed to address MEM_DEPTH words; pointer
    // values never exceed MEM_DEPTH-1, so the upper pointer bits are zero.
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    // Wide enough for both the payload and a pointer.
    localparam int PW    = (MEM_WIDTH > ADDR_SIZE) ? MEM_WIDTH : ADDR_SIZE;
    localparam logic [ADDR_SIZE-1:0] LAST_PTR = ADDR_SIZE'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        CMD_SET_WR = 2'b00,
        CMD_WRITE  = 2'b01,
        CMD_SET_RD = 2'b10,
        CMD_READ   = 2'b11
    } cmd_e;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_PEND = 1'b1
    } tx_state_e;

    // Storage
    logic [MEM_WIDTH-1:0] mem [0:MEM_DEPTH-1];

    // State and registered outputs
    tx_state_e            state_q,    state_d;
    logic [ADDR_SIZE-1:0] wr_ptr_q,   wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q,   rd_ptr_d;
    logic [MEM_WIDTH-1:0] dout_q,     dout_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 overrun_q,  overrun_d;
    logic                 addr_err_q, addr_err_d;

    // Decoded command fields
    cmd_e                 cmd;
    logic [MEM_WIDTH-1:0] payload;
    logic [PW-1:0]        payload_ext;
    logic [ADDR_SIZE-1:0] payload_ptr;
    logic                 payload_in_range;

    // Per-cycle events
    logic                 mem_we;
    logic                 read_accept;
    logic                 overrun_set;
    logic                 addr_err_set;

    // Post-increment with wrap at the last valid word.
    function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
        return (p == LAST_PTR) ? '0 : p + ADDR_SIZE'(1);
    endfunction

    assign cmd         = cmd_e'(bus.din[MEM_WIDTH+1:MEM_WIDTH]);
    assign payload     = bus.din[MEM_WIDTH-1:0];
    assign payload_ext = PW'(payload);
    assign payload_ptr = payload_ext[ADDR_SIZE-1:0];
    // Compare in one extra bit so MEM_DEPTH == 2^ADDR_SIZE does not overflow;
    // payload bits above the pointer width take part in the check.
    assign payload_in_range = ({1'b0, payload_ext} < (PW + 1)'(MEM_DEPTH));

    // Command decode, transmit handshake and sticky-flag next state.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        dout_d       = dout_q;
        mem_we       = 1'b0;
        read_accept  = 1'b0;
        overrun_set  = 1'b0;
        addr_err_set = 1'b0;

        if (bus.rx_valid) begin
            unique case (cmd)
                CMD_SET_WR: begin
                    if (payload_in_range) wr_ptr_d = payload_ptr;
                    else                  addr_err_set = 1'b1;
                end
                CMD_WRITE: begin
                    mem_we = 1'b1;
                    if (AUTO_INC) wr_ptr_d = ptr_inc(wr_ptr_q);
                end
                CMD_SET_RD: begin
                    if (payload_in_range) rd_ptr_d = payload_ptr;
                    else                  addr_err_set = 1'b1;
                end
                CMD_READ: begin
                    // A pending word may be replaced only in the same cycle
                    // the slave takes it; otherwise the read is lost.
                    if (state_q == TX_IDLE || bus.tx_ready) read_accept = 1'b1;
                    else                                    overrun_set = 1'b1;
                end
            endcase
        end

        if (read_accept) begin
            dout_d  = mem[rd_ptr_q[IDX_W-1:0]];
            state_d = TX_PEND;
            if (AUTO_INC) rd_ptr_d = ptr_inc(rd_ptr_q);
        end else if (state_q == TX_PEND && bus.tx_ready) begin
            state_d = TX_IDLE;
        end

        tx_valid_d = (state_d == TX_PEND);
        // Set has priority over clear when both happen in one cycle.
        overrun_d  = (overrun_q  & ~bus.clr_err) | overrun_set;
        addr_err_d = (addr_err_q & ~bus.clr_err) | addr_err_set;
    end

    // Transmit FSM, pointers, registered outputs and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q    <= TX_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
            overrun_q  <= overrun_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so it maps onto RAM and keeps its
        // contents across rst_n.
        if (mem_we) mem[wr_ptr_q[IDX_W-1:0]] <= payload;
    end

    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.overrun  = overrun_q;
    assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Bench for spi_ram_burst: three configurations (256/no-inc, 256/auto-inc,
// 100/auto-inc) share one stimulus stream and are compared every cycle
// against a behavioural model, with literal expectations on directed cases.
module tb_spi_ram_burst;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [9:0] din = '0;
    logic       tx_ready = 1'b0;
    logic       clr_err = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    spi_ram_burst_if #(.MEM_WIDTH(8)) bus0 ();
    spi_ram_burst_if #(.MEM_WIDTH(8)) bus1 ();
    spi_ram_burst_if #(.MEM_WIDTH(8)) bus2 ();

    assign bus0.rx_valid = rx_valid; assign bus0.din = din;
    assign bus0.tx_ready = tx_ready; assign bus0.clr_err = clr_err;
    assign bus1.rx_valid = rx_valid; assign bus1.din = din;
    assign bus1.tx_ready = tx_ready; assign bus1.clr_err = clr_err;
    assign bus2.rx_valid = rx_valid; assign bus2.din = din;
    assign bus2.tx_ready = tx_ready; assign bus2.clr_err = clr_err;

    spi_ram_burst #(.MEM_WIDTH(8), .ADDR_SIZE(8), .MEM_DEPTH(256), .AUTO_INC(1'b0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    spi_ram_burst #(.MEM_WIDTH(8), .ADDR_SIZE(8), .MEM_DEPTH(256), .AUTO_INC(1'b1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    spi_ram_burst #(.MEM_WIDTH(8), .ADDR_SIZE(8), .MEM_DEPTH(100), .AUTO_INC(1'b1))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    logic [7:0] d_dout [3];
    logic       d_tv   [3];
    logic       d_ovr  [3];
    logic       d_aerr [3];

    assign d_dout[0] = bus0.dout; assign d_tv[0] = bus0.tx_valid;
    assign d_ovr[0]  = bus0.overrun; assign d_aerr[0] = bus0.addr_err;
    assign d_dout[1] = bus1.dout; assign d_tv[1] = bus1.tx_valid;
    assign d_ovr[1]  = bus1.overrun; assign d_aerr[1] = bus1.addr_err;
    assign d_dout[2] = bus2.dout; assign d_tv[2] = bus2.tx_valid;
    assign d_ovr[2]  = bus2.overrun; assign d_aerr[2] = bus2.addr_err;

    function automatic int depth_of(input int k);
        return (k == 2) ? 100 : 256;
    endfunction

    function automatic bit auto_of(input int k);
        return (k != 0);
    endfunction

    function automatic logic [7:0] f_init(input int a);
        return 8'((a * 37 + 5) & 255);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_mem  [3][256];
    int         m_wp   [3];
    int         m_rp   [3];
    logic [7:0] m_dout [3];
    logic       m_tv   [3];
    logic       m_ovr  [3];
    logic       m_aerr [3];
    bit         acc, oset, aset;
    int         pl;

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_wp[k] = 0; m_rp[k] = 0; m_dout[k] = 8'h00;
                m_tv[k] = 1'b0; m_ovr[k] = 1'b0; m_aerr[k] = 1'b0;
            end else begin
                acc = 1'b0; oset = 1'b0; aset = 1'b0;
                pl  = int'(din[7:0]);
                if (rx_valid) begin
                    case (din[9:8])
                        2'b00: if (pl < depth_of(k)) m_wp[k] = pl; else aset = 1'b1;
                        2'b01: begin
                            m_mem[k][m_wp[k]] = din[7:0];
                            if (auto_of(k)) m_wp[k] = (m_wp[k] + 1) % depth_of(k);
                        end
                        2'b10: if (pl < depth_of(k)) m_rp[k] = pl; else aset = 1'b1;
                        default: if (!m_tv[k] || tx_ready) acc = 1'b1; else oset = 1'b1;
                    endcase
                end
                if (acc) begin
                    m_dout[k] = m_mem[k][m_rp[k]];
                    m_tv[k]   = 1'b1;
                    if (auto_of(k)) m_rp[k] = (m_rp[k] + 1) % depth_of(k);
                end else if (tx_ready) begin
                    m_tv[k] = 1'b0;
                end
                m_ovr[k]  = (m_ovr[k]  && !clr_err) || oset;
                m_aerr[k] = (m_aerr[k] && !clr_err) || aset;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("model_dout%0d", k), 32'(d_dout[k]), 32'(m_dout[k]));
                check($sformatf("model_tx_valid%0d", k), 32'(d_tv[k]), 32'(m_tv[k]));
                check($sformatf("model_overrun%0d", k), 32'(d_ovr[k]), 32'(m_ovr[k]));
                check($sformatf("model_addr_err%0d", k), 32'(d_aerr[k]), 32'(m_aerr[k]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input bit [1:0] c, input logic [7:0] p,
                        input bit rdy, input bit clr);
        rx_valid = v;
        din      = {c, p};
        tx_ready = rdy;
        clr_err  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_tx_valid%0d", k), 32'(d_tv[k]), 32'h0);
            check($sformatf("reset_dout%0d", k), 32'(d_dout[k]), 32'h0);
        end

        // Fill every word with a known pattern (descending, so the depth-100
        // instance ends with correct data at 0..99).
        for (int a = 255; a >= 0; a--) begin
            step(1'b1, 2'b00, 8'(a), 1'b1, 1'b0);
            step(1'b1, 2'b01, f_init(a), 1'b1, 1'b0);
        end
        check("init_addr_err_d100", 32'(d_aerr[2]), 32'h1);
        check("init_addr_err_d256", 32'(d_aerr[0]), 32'h0);
        step(1'b0, 2'b00, 8'h00, 1'b1, 1'b1);
        check("clr_addr_err_d100", 32'(d_aerr[2]), 32'h0);

        // Single write / read.
        step(1'b1, 2'b00, 8'h10, 1'b1, 1'b0);
        step(1'b1, 2'b01, 8'hA5, 1'b1, 1'b0);
        step(1'b1, 2'b10, 8'h10, 1'b1, 1'b0);
        step(1'b1, 2'b11, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("single_dout%0d", k), 32'(d_dout[k]), 32'hA5);
            check($sformatf("single_tv%0d", k), 32'(d_tv[k]), 32'h1);
        end
        step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++)
            check($sformatf("single_tv_drop%0d", k), 32'(d_tv[k]), 32'h0);

        // Burst with wrap on the 256-deep auto-increment instance.
        step(1'b1, 2'b00, 8'hFE, 1'b1, 1'b0);
        step(1'b1, 2'b01, 8'h11, 1'b1, 1'b0);
        step(1'b1, 2'b01, 8'h22, 1'b1, 1'b0);
        step(1'b1, 2'b01, 8'h33, 1'b1, 1'b0);
        step(1'b1, 2'b10, 8'hFE, 1'b1, 1'b0);
        step(1'b1, 2'b11, 8'h00, 1'b1, 1'b0);
        check("burst_d0", 32'(d_dout[1]), 32'h11); check("burst_tv0", 32'(d_tv[1]), 32'h1);
        step(1'b1, 2'b11, 8'h00, 1'b1, 1'b0);
        check("burst_d1", 32'(d_dout[1]), 32'h22); check("burst_tv1", 32'(d_tv[1]), 32'h1);
        step(1'b1, 2'b11, 8'h00, 1'b1, 1'b0);
        check("burst_d2", 32'(d_dout[1]), 32'h33); check("burst_tv2", 32'(d_tv[1]), 32'h1);
        step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
        step(1'b1, 2'b10, 8'h00, 1'b1, 1'b0);
        step(1'b1, 2'b11, 8'h00, 1'b1, 1'b0);
        check("burst_wrap_addr0", 32'(d_dout[1]), 32'h33);
        step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);

        // Back-pressure and overrun.
        step(1'b1, 2'b10, 8'h10, 1'b0, 1'b0);
        step(1'b1, 2'b11, 8'h00, 1'b0, 1'b0);
        step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_hold_dout%0d", k), 32'(d_dout[k]), 32'hA5);
            check($sformatf("bp_hold_tv%0d", k), 32'(d_tv[k]), 32'h1);
        end
        step(1'b1, 2'b11, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ovr_set%0d", k), 32'(d_ovr[k]), 32'h1);
            check($sformatf("ovr_dout%0d", k), 32'(d_dout[k]), 32'hA5);
        end
        step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
        check("bp_release_tv", 32'(d_tv[0]), 32'h0);
        check("ovr_sticky", 32'(d_ovr[0]), 32'h1);
        step(1'b0, 2'b00, 8'h00, 1'b0, 1'b1);
        check("ovr_clear", 32'(d_ovr[0]), 32'h0);

        // Non-power-of-2 depth: range check and wrap.
        step(1'b1, 2'b00, 8'd50, 1'b1, 1'b0);
        step(1'b1, 2'b00, 8'd120, 1'b1, 1'b0);
        check("d100_addr_err", 32'(d_aerr[2]), 32'h1);
        check("d256_no_addr_err", 32'(d_aerr[1]), 32'h0);
        step(1'b1, 2'b01, 8'h5C, 1'b1, 1'b0);
        step(1'b1, 2'b10, 8'd50, 1'b1, 1'b0);
        step(1'b1, 2'b11, 8'h00, 1'b1, 1'b0);
        check("d100_wr_ptr_kept", 32'(d_dout[2]), 32'h5C);
        step(1'b1, 2'b00, 8'd99, 1'b1, 1'b0);
        step(1'b1, 2'b01, 8'h77, 1'b1, 1'b0);
        step(1'b1, 2'b01, 8'h88, 1'b1, 1'b0);
        step(1'b1, 2'b10, 8'd0, 1'b1, 1'b0);
        step(1'b1, 2'b11, 8'h00, 1'b1, 1'b0);
        check("d100_wrap_addr0", 32'(d_dout[2]), 32'h88);
        check("d256_addr0_kept", 32'(d_dout[1]), 32'h33);
        step(1'b1, 2'b10, 8'd99, 1'b1, 1'b0);
        step(1'b1, 2'b11, 8'h00, 1'b1, 1'b0);
        check("d100_addr99", 32'(d_dout[2]), 32'h77);
        step(1'b0, 2'b00, 8'h00, 1'b1, 1'b1);
        check("d100_addr_err_clr", 32'(d_aerr[2]), 32'h0);

        // Async reset while a word is pending.
        step(1'b1, 2'b10, 8'h10, 1'b0, 1'b0);
        step(1'b1, 2'b11, 8'h00, 1'b0, 1'b0);
        step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        check("pre_rst_tv", 32'(d_tv[0]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("async_rst_tv%0d", k), 32'(d_tv[k]), 32'h0);
            check($sformatf("async_rst_dout%0d", k), 32'(d_dout[k]), 32'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 2'b10, 8'h10, 1'b1, 1'b0);
        step(1'b1, 2'b11, 8'h00, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++)
            check($sformatf("mem_retained%0d", k), 32'(d_dout[k]), 32'hA5);

        // rx_valid gating: cmd 11 without rx_valid does nothing.
        step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) begin
            step(1'b0, 2'b11, 8'h00, 1'b1, 1'b0);
            check($sformatf("gated_tv_c%0d", n), 32'(d_tv[1]), 32'h0);
        end
        step(1'b1, 2'b11, 8'h00, 1'b1, 1'b0);
        check("gated_rd_ptr0", 32'(d_dout[0]), 32'hA5);
        check("gated_rd_ptr1", 32'(d_dout[1]), 32'h7A);
        check("gated_rd_ptr2", 32'(d_dout[2]), 32'h11);
        step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);

        // Randomized traffic, checked every cycle by the model compare.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] p;
            p = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 127)) : 8'($urandom);
            step($urandom_range(0, 9) < 8, 2'($urandom), p,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
            if (i % 997 == 500) reset_pulse();
        end
        step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
        step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
